// File: rtl/reg_file_pkg.sv
// reg_file_pkg -- shared constants and types for the register file slice.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   N_RD_MIN..N_RD_MAX      : legal number of read ports
//   N_WR_MIN..N_WR_MAX      : legal number of write ports
//   reg_addr_t              : register address type at the default width
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int N_RD_MIN = 1;
    localparam int N_RD_MAX = 4;
    localparam int N_WR_MIN = 1;
    localparam int N_WR_MAX = 2;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // True when a port count lies inside its legal range.
    function automatic bit in_range(int n, int lo, int hi);
        return (n >= lo) && (n <= hi);
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if -- bus between a register-file client (master) and reg_file (slave).
//   rd_addr  : N_RD packed read addresses, port i in slice i
//   rd_data  : N_RD packed read data, combinational from rd_addr
//   rd_busy  : scoreboard busy bit for each read address
//   wr_en    : N_WR write enables; wr_addr/wr_data are meaningful only while set
//   iss_en   : issue strobe, iss_reg names the destination now pending
//   busy_vec : whole scoreboard, bit r = register r pending
// Handshake: there is no back-pressure. wr_en[k] and iss_en are single-cycle
// valid strobes that are always accepted at the next rising clock edge.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_RD   = 2,
    parameter int N_WR   = 1
) ();

    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic [N_RD-1:0]        rd_busy;
    logic [N_WR-1:0]        wr_en;
    logic [N_WR*ADDR_W-1:0] wr_addr;
    logic [N_WR*DATA_W-1:0] wr_data;
    logic                   iss_en;
    logic [ADDR_W-1:0]      iss_reg;
    logic [(2**ADDR_W)-1:0] busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_reg,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_reg,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard -- one pending-producer bit per register.
//   clk_i, rst_i : clock, synchronous active-high reset (clears every bit)
//   iss_en_i     : issue strobe, iss_reg_i becomes pending
//   wr_en_i      : write enables, a written register stops being pending
//   wr_addr_i    : packed write addresses
//   busy_o       : registered scoreboard, bit 0 is always 0
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_WR   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   iss_en_i,
    input  logic [ADDR_W-1:0]      iss_reg_i,
    input  logic [N_WR-1:0]        wr_en_i,
    input  logic [N_WR*ADDR_W-1:0] wr_addr_i,
    output logic [(2**ADDR_W)-1:0] busy_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clears are applied before the set so an issue in the same cycle as a
    // write to the same register leaves it pending: the newer producer wins.
    // A single bit per register means repeated issues do not stack.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < N_WR; k++) begin
            if (wr_en_i[k]) begin
                busy_d[wr_addr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_en_i) begin
            busy_d[iss_reg_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/reg_file.sv
// reg_file -- multi-ported register file with a busy scoreboard.
//   clk_i : sole clock, all state updates on the rising edge
//   rst_i : synchronous active-high reset, clears data and busy bits and
//           discards writes/issues in the same cycle
//   bus   : reg_file_if.slave (read ports, write ports, issue, busy_vec)
// Register 0 reads as zero and ignores writes and issues.
// Optional macro REG_FILE_BYPASS_EN: a read that matches an enabled nonzero
// write in the same cycle returns that write's data (highest port wins) and
// reports not-busy unless the same register is also being issued.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_RD   = 2,
    parameter int N_WR   = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    reg_file_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    if (!in_range(N_RD, N_RD_MIN, N_RD_MAX)) begin : g_bad_n_rd
        $error("reg_file: N_RD=%0d outside %0d..%0d", N_RD, N_RD_MIN, N_RD_MAX);
    end
    if (!in_range(N_WR, N_WR_MIN, N_WR_MAX)) begin : g_bad_n_wr
        $error("reg_file: N_WR=%0d outside %0d..%0d", N_WR, N_WR_MIN, N_WR_MAX);
    end

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_vec;

    // Ports are visited in ascending order so the highest index wins a
    // same-address collision.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < N_WR; k++) begin
            if (bus.wr_en[k] && (bus.wr_addr[k*ADDR_W +: ADDR_W] != '0)) begin
                regs_d[bus.wr_addr[k*ADDR_W +: ADDR_W]] = bus.wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_scoreboard #(
        .ADDR_W (ADDR_W),
        .N_WR   (N_WR)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .iss_en_i  (bus.iss_en),
        .iss_reg_i (bus.iss_reg),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .busy_o    (busy_vec)
    );

    assign bus.busy_vec = busy_vec;

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdata;
        logic              rbusy;

        assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            // Register 0 is forced to zero so it reads cleanly even before reset.
            rdata = (ra == '0) ? '0 : regs_q[ra];
            rbusy = busy_vec[ra];
`ifdef REG_FILE_BYPASS_EN
            for (int k = 0; k < N_WR; k++) begin
                if (bus.wr_en[k] && (ra != '0) && (bus.wr_addr[k*ADDR_W +: ADDR_W] == ra)) begin
                    rdata = bus.wr_data[k*DATA_W +: DATA_W];
                    rbusy = bus.iss_en && (bus.iss_reg == ra);
                end
            end
`endif
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = rdata;
        assign bus.rd_busy[i] = rbusy;
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file -- self-checking bench for reg_file (N_RD=2, N_WR=2).
module tb_reg_file;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_RD = 2;
  localparam int N_WR = 2;
  localparam int DEPTH = 2**ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .N_WR(N_WR)) bus ();

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .N_WR(N_WR)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // reference model: architectural register contents and pending bits
  logic [DATA_W-1:0] m_regs [DEPTH];
  logic m_busy [DEPTH];
  int passed = 0;
  int total = 0;

  // driver tasks
  task automatic drive_idle();
    rst = 1'b0;
    bus.wr_en = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.iss_en = 1'b0;
    bus.iss_reg = '0;
  endtask

  task automatic drive_write(input int port, input int addr, input logic [DATA_W-1:0] data);
    bus.wr_en[port] = 1'b1;
    bus.wr_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    bus.wr_data[port*DATA_W +: DATA_W] = data;
  endtask

  task automatic drive_issue(input int addr);
    bus.iss_en = 1'b1;
    bus.iss_reg = ADDR_W'(addr);
  endtask

  task automatic drive_read(input int port, input int addr);
    bus.rd_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
  endtask

  // Advance one clock; the model applies the architectural rules to the
  // inputs present at that edge.
  task automatic tick();
    logic [DATA_W-1:0] nr [DEPTH];
    logic nb [DEPTH];
    nr = m_regs;
    nb = m_busy;
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        nr[r] = '0;
        nb[r] = 1'b0;
      end
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        int a;
        a = int'(bus.wr_addr[k*ADDR_W +: ADDR_W]);
        if (bus.wr_en[k] && a != 0) begin
          nr[a] = bus.wr_data[k*DATA_W +: DATA_W];
          nb[a] = 1'b0;
        end
      end
      if (bus.iss_en && bus.iss_reg != '0) nb[int'(bus.iss_reg)] = 1'b1;
    end
    @(posedge clk);
    #1;
    m_regs = nr;
    m_busy = nb;
  endtask

  // expected combinational read value for the inputs currently driven
  function automatic logic [DATA_W-1:0] exp_data(input int a);
    logic [DATA_W-1:0] v;
    v = (a == 0) ? '0 : m_regs[a];
`ifdef REG_FILE_BYPASS_EN
    for (int k = 0; k < N_WR; k++)
      if (bus.wr_en[k] && a != 0 && int'(bus.wr_addr[k*ADDR_W +: ADDR_W]) == a)
        v = bus.wr_data[k*DATA_W +: DATA_W];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    logic b;
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REG_FILE_BYPASS_EN
    for (int k = 0; k < N_WR; k++)
      if (bus.wr_en[k] && a != 0 && int'(bus.wr_addr[k*ADDR_W +: ADDR_W]) == a)
        b = bus.iss_en && int'(bus.iss_reg) == a;
`endif
    return b;
  endfunction

  function automatic logic [DEPTH-1:0] exp_busy_vec();
    logic [DEPTH-1:0] v;
    for (int r = 0; r < DEPTH; r++) v[r] = m_busy[r];
    v[0] = 1'b0;
    return v;
  endfunction

  task automatic test_reset();
    // every register and busy bit after the power-on reset
    for (int a = 0; a < DEPTH; a++) begin
      drive_read(0, a);
      drive_read(1, DEPTH - 1 - a);
      #1;
      total++;
      if (bus.rd_data[0 +: DATA_W] !== '0 || bus.rd_busy[0] !== 1'b0) begin
        $display("FAIL reset_init r%0d: data=%h busy=%b want 0/0", a, bus.rd_data[0 +: DATA_W], bus.rd_busy[0]);
      end else passed++;
    end
    total++;
    if (bus.busy_vec !== '0) $display("FAIL reset_init busy_vec: got %h want 0", bus.busy_vec);
    else passed++;

    // dirty the file, then reset with a write and issue in the reset cycle
    for (int c = 0; c < 8; c++) begin
      drive_idle();
      drive_write(0, $urandom_range(1, DEPTH - 1), $urandom);
      drive_issue($urandom_range(1, DEPTH - 1));
      tick();
    end
    drive_idle();
    rst = 1'b1;
    drive_write(1, 4, 32'hCAFEF00D);
    drive_issue(6);
    tick();
    drive_idle();
    for (int a = 0; a < DEPTH; a++) begin
      drive_read(0, a);
      #1;
      total++;
      if (bus.rd_data[0 +: DATA_W] !== '0 || bus.rd_busy[0] !== 1'b0) begin
        $display("FAIL reset_after_writes r%0d: data=%h busy=%b want 0/0", a, bus.rd_data[0 +: DATA_W], bus.rd_busy[0]);
      end else passed++;
    end
    total++;
    if (bus.busy_vec !== '0) $display("FAIL reset_after_writes busy_vec: got %h want 0", bus.busy_vec);
    else passed++;
  endtask

  task automatic test_write_read();
    drive_idle();
    drive_write(0, 5, 32'hDEADBEEF);
    tick();
    drive_idle();
    drive_read(1, 5);
    #1;
    total++;
    if (bus.rd_data[DATA_W +: DATA_W] !== 32'hDEADBEEF)
      $display("FAIL write_r5: got %h want deadbeef", bus.rd_data[DATA_W +: DATA_W]);
    else passed++;

    drive_write(1, 0, 32'h1234);
    drive_issue(0);
    tick();
    drive_idle();
    drive_read(0, 0);
    #1;
    total++;
    if (bus.rd_data[0 +: DATA_W] !== '0 || bus.rd_busy[0] !== 1'b0 || bus.busy_vec[0] !== 1'b0)
      $display("FAIL write_r0: data=%h busy=%b vec0=%b want 0/0/0", bus.rd_data[0 +: DATA_W], bus.rd_busy[0], bus.busy_vec[0]);
    else passed++;
  endtask

  task automatic test_dual_write();
    drive_idle();
    drive_write(0, 7, 32'h11);
    drive_write(1, 7, 32'h22);
    tick();
    drive_idle();
    drive_read(0, 7);
    #1;
    total++;
    if (bus.rd_data[0 +: DATA_W] !== 32'h22)
      $display("FAIL dual_write_r7: got %h want 00000022", bus.rd_data[0 +: DATA_W]);
    else passed++;
  endtask

  task automatic test_scoreboard();
    drive_idle();
    drive_read(1, 3);
    drive_issue(3);
    tick();
    drive_idle();
    #1;
    total++;
    if (bus.busy_vec[3] !== 1'b1 || bus.rd_busy[1] !== 1'b1)
      $display("FAIL issue_sets_r3: vec=%b rd_busy=%b want 1/1", bus.busy_vec[3], bus.rd_busy[1]);
    else passed++;

    drive_write(0, 3, 32'h3);
    tick();
    drive_idle();
    #1;
    total++;
    if (bus.busy_vec[3] !== 1'b0) $display("FAIL write_clears_r3: got %b want 0", bus.busy_vec[3]);
    else passed++;

    drive_write(1, 3, 32'h33);
    drive_issue(3);
    tick();
    drive_idle();
    #1;
    total++;
    if (bus.busy_vec[3] !== 1'b1) $display("FAIL issue_write_same_r3: got %b want 1", bus.busy_vec[3]);
    else passed++;

    // second issue to a busy register, then a single write must clear it
    drive_issue(3);
    tick();
    drive_idle();
    drive_write(0, 3, 32'h333);
    tick();
    drive_idle();
    #1;
    total++;
    if (bus.busy_vec !== exp_busy_vec() || bus.busy_vec[3] !== 1'b0)
      $display("FAIL no_count_r3: got %h want %h", bus.busy_vec, exp_busy_vec());
    else passed++;
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] want_d;
    logic want_b;
    drive_idle();
    drive_issue(9);
    tick();
    drive_idle();
    drive_read(0, 9);
    drive_write(0, 9, 32'hA5A5A5A5);
    #1;
`ifdef REG_FILE_BYPASS_EN
    want_d = 32'hA5A5A5A5;
    want_b = 1'b0;
`else
    want_d = '0;
    want_b = 1'b1;
`endif
    total++;
    if (bus.rd_data[0 +: DATA_W] !== want_d || bus.rd_busy[0] !== want_b)
      $display("FAIL same_cycle_r9: data=%h busy=%b want %h/%b", bus.rd_data[0 +: DATA_W], bus.rd_busy[0], want_d, want_b);
    else passed++;
    tick();
    drive_idle();
    #1;
    total++;
    if (bus.rd_data[0 +: DATA_W] !== 32'hA5A5A5A5 || bus.rd_busy[0] !== 1'b0)
      $display("FAIL after_write_r9: data=%h busy=%b want a5a5a5a5/0", bus.rd_data[0 +: DATA_W], bus.rd_busy[0]);
    else passed++;

    // write and issue together while reading: pending stays visible
    drive_write(1, 9, 32'h5A5A5A5A);
    drive_issue(9);
    #1;
`ifdef REG_FILE_BYPASS_EN
    want_d = 32'h5A5A5A5A;
    want_b = 1'b1;
`else
    want_d = 32'hA5A5A5A5;
    want_b = 1'b0;
`endif
    total++;
    if (bus.rd_data[0 +: DATA_W] !== want_d || bus.rd_busy[0] !== want_b)
      $display("FAIL same_cycle_issue_r9: data=%h busy=%b want %h/%b", bus.rd_data[0 +: DATA_W], bus.rd_busy[0], want_d, want_b);
    else passed++;
    tick();
    drive_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_idle();
      for (int p = 0; p < N_RD; p++) drive_read(p, $urandom_range(0, 7));
      for (int k = 0; k < N_WR; k++)
        if ($urandom_range(0, 1) == 1) drive_write(k, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 2) == 0) drive_issue($urandom_range(0, 7));
      #1;
      for (int p = 0; p < N_RD; p++) begin
        int a;
        a = int'(bus.rd_addr[p*ADDR_W +: ADDR_W]);
        total++;
        if (bus.rd_data[p*DATA_W +: DATA_W] !== exp_data(a) || bus.rd_busy[p] !== exp_busy(a))
          $display("FAIL random c%0d port%0d r%0d: data=%h busy=%b want %h/%b", c, p, a,
                   bus.rd_data[p*DATA_W +: DATA_W], bus.rd_busy[p], exp_data(a), exp_busy(a));
        else passed++;
      end
      total++;
      if (bus.busy_vec !== exp_busy_vec())
        $display("FAIL random c%0d busy_vec: got %h want %h", c, bus.busy_vec, exp_busy_vec());
      else passed++;
      tick();
    end
    drive_idle();
  endtask

  initial begin
    for (int r = 0; r < DEPTH; r++) begin
      m_regs[r] = 'x;
      m_busy[r] = 1'bx;
    end
    drive_idle();
    bus.rd_addr = '0;
    rst = 1'b1;
    tick();
    tick();
    drive_idle();

    test_reset();
    test_write_read();
    test_dual_write();
    test_scoreboard();
    test_bypass();
    test_random();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
